// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - BTB sizing, field extraction and update-entry types
package btb_pkg;

  localparam int NUM_BTB_ENTRIES     = 1024;
  localparam int LOG_NUM_BTB_ENTRIES = 10;
  localparam int TAG_LENGTH          = 10;
  localparam int DISPL_BITS          = 19;
  localparam int FIFO_DEPTH          = 4;

  typedef struct packed {
    logic                           valid;
    logic [LOG_NUM_BTB_ENTRIES-1:0] idx;
    logic [TAG_LENGTH-1:0]          tag;
    logic [DISPL_BITS-1:0]          target;
  } btb_upd_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } btb_state_e;

  function automatic logic [LOG_NUM_BTB_ENTRIES-1:0] btb_idx(input logic [63:0] pc);
    return LOG_NUM_BTB_ENTRIES'(pc >> 2);
  endfunction

  function automatic logic [TAG_LENGTH-1:0] btb_tag(input logic [63:0] pc);
    return TAG_LENGTH'(pc >> (LOG_NUM_BTB_ENTRIES + 2));
  endfunction

  function automatic logic [DISPL_BITS-1:0] btb_target(input logic [63:0] npc);
    return DISPL_BITS'(npc >> 2);
  endfunction

  function automatic btb_upd_t btb_make_upd(input logic [63:0] pc, input logic [63:0] npc);
    return '{valid: 1'b1, idx: btb_idx(pc), tag: btb_tag(pc), target: btb_target(npc)};
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - pending BTB update queue; optional in-place coalesce (BTB_UPD_COALESCE_EN)
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     upd_en,
  input  btb_upd_t                 upd,
  input  logic                     pop,
  output btb_upd_t                 head,
  output logic                     hit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  btb_upd_t          mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     hit_slot;
  logic              push;

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // The head is excluded from the match: it may be leaving on this very cycle.
  always_comb begin
    hit      = 1'b0;
    hit_slot = rd_ptr;
`ifdef BTB_UPD_COALESCE_EN
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (CW'(i) < cnt && mem[rd_ptr + PW'(i)].valid && mem[rd_ptr + PW'(i)].idx == upd.idx) begin
        hit      = 1'b1;
        hit_slot = rd_ptr + PW'(i);
      end
    end
`endif
  end

  assign push = upd_en && !hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= upd;
    else if (upd_en && hit)
      mem[hit_slot] <= upd;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-port controller: table invalidate walk, update arbitration, drain (BTB_UPD_COALESCE_EN)
module btb_update_ctrl
  import btb_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear_req,
  input  logic                           rob_mis_pred,
  input  logic [63:0]                    rob_mis_pred_pc,
  input  logic [63:0]                    rob_correct_npc,
  output logic                           mis_ready,
  input  logic                           rt_alloc_valid,
  input  logic [63:0]                    rt_alloc_pc,
  input  logic [63:0]                    rt_alloc_target,
  output logic                           alloc_ready,
  output logic                           btb_wr_en,
  output logic [LOG_NUM_BTB_ENTRIES-1:0] btb_wr_idx,
  output logic                           btb_wr_valid,
  output logic [TAG_LENGTH-1:0]          btb_wr_tag,
  output logic [DISPL_BITS-1:0]          btb_wr_target,
  output logic                           btb_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  btb_state_e                     state;
  logic [LOG_NUM_BTB_ENTRIES-1:0] clr_idx;
  logic                           run;
  logic                           accept_ok;
  logic                           upd_en;
  logic                           pop;
  btb_upd_t                       sel_upd;
  btb_upd_t                       head;
  logic                           hit;
  logic                           full;
  logic                           empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (clear_req) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + LOG_NUM_BTB_ENTRIES'(1);
      if (clr_idx == LOG_NUM_BTB_ENTRIES'(NUM_BTB_ENTRIES - 1))
        state <= RUN;
    end
  end

  assign run       = (state == RUN);
  assign btb_ready = run;

  // A clear request discards everything pending, so nothing is accepted or drained on that cycle.
  assign accept_ok   = run && !clear_req;
  assign sel_upd     = rob_mis_pred ? btb_make_upd(rob_mis_pred_pc, rob_correct_npc)
                                    : btb_make_upd(rt_alloc_pc, rt_alloc_target);
  assign mis_ready   = accept_ok && (!full || (rob_mis_pred && hit));
  assign alloc_ready = accept_ok && !rob_mis_pred && (!full || hit);
  assign upd_en      = (rob_mis_pred && mis_ready) || (rt_alloc_valid && alloc_ready);
  assign pop         = accept_ok && !empty;

  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .flush  (clear_req),
    .upd_en (upd_en),
    .upd    (sel_upd),
    .pop    (pop),
    .head   (head),
    .hit    (hit),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  // Reset forces CLEAR asynchronously; the invalidate strobe must stay low while it is held.
  always_comb begin
    btb_wr_en     = 1'b0;
    btb_wr_idx    = '0;
    btb_wr_valid  = 1'b0;
    btb_wr_tag    = '0;
    btb_wr_target = '0;
    if (!run) begin
      btb_wr_en  = reset;
      btb_wr_idx = reset ? clr_idx : '0;
    end else if (pop) begin
      btb_wr_en     = 1'b1;
      btb_wr_idx    = head.idx;
      btb_wr_valid  = head.valid;
      btb_wr_tag    = head.tag;
      btb_wr_target = head.target;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear_req = 1'b0;
  logic        rob_mis_pred = 1'b0;
  logic [63:0] rob_mis_pred_pc = '0;
  logic [63:0] rob_correct_npc = '0;
  logic        rt_alloc_valid = 1'b0;
  logic [63:0] rt_alloc_pc = '0;
  logic [63:0] rt_alloc_target = '0;
  logic        mis_ready;
  logic        alloc_ready;
  logic        btb_wr_en;
  logic [9:0]  btb_wr_idx;
  logic        btb_wr_valid;
  logic [9:0]  btb_wr_tag;
  logic [18:0] btb_wr_target;
  logic        btb_ready;
  logic [2:0]  fifo_count;

  btb_update_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .clear_req       (clear_req),
    .rob_mis_pred    (rob_mis_pred),
    .rob_mis_pred_pc (rob_mis_pred_pc),
    .rob_correct_npc (rob_correct_npc),
    .mis_ready       (mis_ready),
    .rt_alloc_valid  (rt_alloc_valid),
    .rt_alloc_pc     (rt_alloc_pc),
    .rt_alloc_target (rt_alloc_target),
    .alloc_ready     (alloc_ready),
    .btb_wr_en       (btb_wr_en),
    .btb_wr_idx      (btb_wr_idx),
    .btb_wr_valid    (btb_wr_valid),
    .btb_wr_tag      (btb_wr_tag),
    .btb_wr_target   (btb_wr_target),
    .btb_ready       (btb_ready),
    .fifo_count      (fifo_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int idx;
    int tag;
    int tgt;
  } ment_t;

  function automatic ment_t mk(input logic [63:0] pc, input logic [63:0] npc);
    ment_t e;
    e.idx = int'((pc >> 2) & 64'h3FF);
    e.tag = int'((pc >> 12) & 64'h3FF);
    e.tgt = int'((npc >> 2) & 64'h7FFFF);
    return e;
  endfunction

  ment_t mq[$];
  bit    m_clear = 1'b1;
  int    m_cidx = 0;
  int    inv_cnt = 0;
  int    vwr_cnt = 0;
  int    max_cnt = 0;
  int    wr_log[$];

  // Reference model: a table walk counter plus a plain queue of pending writes.
  initial forever begin : model
    bit full;
    bit take;
    bit wr;
    @(negedge clock);
    if (!reset) begin
      chk("rst_wr_en", 32'(btb_wr_en), 0);
      chk("rst_ready", 32'(btb_ready), 0);
      chk("rst_mis_ready", 32'(mis_ready), 0);
      chk("rst_alloc_ready", 32'(alloc_ready), 0);
      chk("rst_count", 32'(fifo_count), 0);
      m_clear = 1'b1;
      m_cidx  = 0;
      mq.delete();
    end else if (m_clear) begin
      chk("clr_wr_en", 32'(btb_wr_en), 1);
      chk("clr_valid", 32'(btb_wr_valid), 0);
      chk("clr_idx", 32'(btb_wr_idx), m_cidx);
      chk("clr_tag", 32'(btb_wr_tag), 0);
      chk("clr_target", 32'(btb_wr_target), 0);
      chk("clr_ready", 32'(btb_ready), 0);
      chk("clr_mis_ready", 32'(mis_ready), 0);
      chk("clr_alloc_ready", 32'(alloc_ready), 0);
      chk("clr_count", 32'(fifo_count), 0);
      inv_cnt++;
      if (clear_req) m_cidx = 0;
      else begin
        m_cidx++;
        if (m_cidx == 1024) m_clear = 1'b0;
      end
    end else begin
      full = (mq.size() >= 4);
      take = !clear_req && !full;
      wr   = (mq.size() > 0) && !clear_req;
      chk("run_ready", 32'(btb_ready), 1);
      chk("run_count", 32'(fifo_count), mq.size());
      chk("run_mis_ready", 32'(mis_ready), 32'(take));
      chk("run_alloc_ready", 32'(alloc_ready), 32'(take && !rob_mis_pred));
      chk("run_wr_en", 32'(btb_wr_en), 32'(wr));
      if (wr) begin
        chk("run_wr_valid", 32'(btb_wr_valid), 1);
        chk("run_wr_idx", 32'(btb_wr_idx), mq[0].idx);
        chk("run_wr_tag", 32'(btb_wr_tag), mq[0].tag);
        chk("run_wr_target", 32'(btb_wr_target), mq[0].tgt);
        wr_log.push_back(mq[0].idx);
        vwr_cnt++;
        void'(mq.pop_front());
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (clear_req) begin
        mq.delete();
        m_clear = 1'b1;
        m_cidx  = 0;
      end else if (rob_mis_pred && take)
        mq.push_back(mk(rob_mis_pred_pc, rob_correct_npc));
      else if (rt_alloc_valid && take)
        mq.push_back(mk(rt_alloc_pc, rt_alloc_target));
    end
  end

  task automatic to_drive;
    @(posedge clock);
    #1;
  endtask

  task automatic to_sample;
    @(negedge clock);
    #2;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    forever begin
      to_sample();
      if (btb_ready === 1'b1) break;
      cyc++;
      if (cyc >= 3000) break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int cyc;
    repeat (3) to_sample();
    chk("reset_wr_en", 32'(btb_wr_en), 0);
    chk("reset_btb_ready", 32'(btb_ready), 0);
    chk("reset_count", 32'(fifo_count), 0);

    // Power-up invalidate walk
    to_drive();
    reset   = 1'b1;
    inv_cnt = 0;
    wait_ready(cyc);
    chk("init_clear_cycles", cyc, 1024);
    chk("init_inv_writes", inv_cnt, 1024);
    chk("init_wr_en_after", 32'(btb_wr_en), 0);

    // Single mispredict
    to_drive();
    rob_mis_pred    = 1'b1;
    rob_mis_pred_pc = 64'h0000_0000_0001_2344;
    rob_correct_npc = 64'h0000_0000_0000_8000;
    to_sample();
    chk("mis_ready", 32'(mis_ready), 1);
    chk("mis_no_bypass", 32'(btb_wr_en), 0);
    to_drive();
    rob_mis_pred = 1'b0;
    to_sample();
    chk("mis_wr_en", 32'(btb_wr_en), 1);
    chk("mis_wr_idx", 32'(btb_wr_idx), 32'h0D1);
    chk("mis_wr_tag", 32'(btb_wr_tag), 32'h012);
    chk("mis_wr_target", 32'(btb_wr_target), 32'h02000);
    chk("mis_wr_valid", 32'(btb_wr_valid), 1);

    // Simultaneous mispredict and allocation
    to_drive();
    rob_mis_pred    = 1'b1;
    rob_mis_pred_pc = 64'h0000_0000_4000_1008;
    rob_correct_npc = 64'h0000_0000_1234_5678;
    rt_alloc_valid  = 1'b1;
    rt_alloc_pc     = 64'h0000_0000_0000_3010;
    rt_alloc_target = 64'h0000_0000_0000_0044;
    to_sample();
    chk("both_mis_ready", 32'(mis_ready), 1);
    chk("both_alloc_ready", 32'(alloc_ready), 0);
    to_drive();
    rob_mis_pred = 1'b0;
    to_sample();
    chk("both_alloc_next", 32'(alloc_ready), 1);
    chk("both_first_idx", 32'(btb_wr_idx), 32'h002);
    chk("both_first_tag", 32'(btb_wr_tag), 32'h001);
    chk("both_first_target", 32'(btb_wr_target), 32'h5159E);
    to_drive();
    rt_alloc_valid = 1'b0;
    to_sample();
    chk("both_second_idx", 32'(btb_wr_idx), 32'h004);
    chk("both_second_tag", 32'(btb_wr_tag), 32'h003);
    chk("both_second_target", 32'(btb_wr_target), 32'h011);

    // Five back-to-back allocations
    wr_log.delete();
    max_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      to_drive();
      rt_alloc_valid  = 1'b1;
      rt_alloc_pc     = 64'h1000 + 64'(i * 4);
      rt_alloc_target = 64'h8000 + 64'(i * 8);
      to_sample();
      chk("b2b_alloc_ready", 32'(alloc_ready), 1);
    end
    to_drive();
    rt_alloc_valid = 1'b0;
    repeat (3) to_sample();
    chk("b2b_write_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++)
      chk("b2b_write_order", wr_log[i], i);
    chk("b2b_max_count", max_cnt, 1);

    // clear_req with an update pending
    to_drive();
    rt_alloc_valid  = 1'b1;
    rt_alloc_pc     = 64'h2A8;
    rt_alloc_target = 64'h100;
    to_drive();
    rt_alloc_valid = 1'b0;
    clear_req      = 1'b1;
    vwr_cnt        = 0;
    inv_cnt        = 0;
    to_sample();
    chk("clrq_pending_count", 32'(fifo_count), 1);
    chk("clrq_no_drain", 32'(btb_wr_en), 0);
    to_drive();
    clear_req = 1'b0;
    wait_ready(cyc);
    chk("clrq_clear_cycles", cyc, 1024);
    chk("clrq_inv_writes", inv_cnt, 1024);
    chk("clrq_pending_dropped", vwr_cnt, 0);

    // Reset in the middle of a clear
    to_drive();
    clear_req = 1'b1;
    to_drive();
    clear_req = 1'b0;
    cyc = 0;
    forever begin
      to_sample();
      if (btb_wr_en === 1'b1 && btb_wr_idx == 10'd500) break;
      cyc++;
      if (cyc > 2000) break;
    end
    chk("mid_idx_reached", 32'(btb_wr_idx), 500);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(btb_wr_en), 0);
    chk("mid_rst_idx", 32'(btb_wr_idx), 0);
    chk("mid_rst_ready", 32'(btb_ready), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    to_sample();
    to_drive();
    reset = 1'b1;
    to_sample();
    chk("mid_restart_en", 32'(btb_wr_en), 1);
    chk("mid_restart_idx", 32'(btb_wr_idx), 0);
    wait_ready(cyc);
    chk("mid_restart_cycles", cyc, 1023);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
